seq_mul_256bit: RTL and testbench
=================================

// Module: seq_mul_256bit
// PURPOSE
//  Sequential 256x256 unsigned multiplier producing the 512-bit product that feeds
//  the 2^255-19 modular reducer (x input). Processes b one DIGIT_W-bit digit per cycle,
//  LSB first. Start/done handshake matches the reducer so done->start can be chained.
// PARAMETERS
//  DIGIT_W  16  bits of b consumed per cycle; legal: 1,2,4,8,16,32 (must divide 256)
//  (derived) ITER = 256/DIGIT_W  RUN cycles per operation (16 at default)
// PORTS
//  clk      in   1    rising-edge clock
//  rst      in   1    asynchronous reset, active-high
//  start    in   1    request; sampled only in IDLE
//  a        in   256  multiplicand, captured on accepted start
//  b        in   256  multiplier, captured on accepted start
//  busy     out  1    high in RUN and DONE states
//  done     out  1    one-cycle pulse: product valid
//  product  out  512  a*b; held stable until next done pulse
// BEHAVIOUR
//  - Reset (async, any state): state=IDLE, busy=0, done=0, product=0, acc=0, cnt=0.
//  - States: IDLE -> RUN -> DONE -> IDLE.
//  - IDLE: start=1 at edge: latch a_r=a, b_r=b, acc=0, cnt=0 -> RUN. start=0: stay.
//  - RUN, each cycle: acc += (a_r * b_r[DIGIT_W-1:0]) << (cnt*DIGIT_W);
//    b_r >>= DIGIT_W; cnt++. After cnt reaches ITER -> DONE.
//  - Partial product a_r*digit is 256+DIGIT_W bits; acc is 512 bits and never overflows
//    (max product 2^512-2^257+1); no carry out kept.
//  - DONE (one cycle): product<=acc, done=1 for this cycle only, -> IDLE.
//  - Latency: start sampled at edge 0; done high in cycle following edge ITER+1
//    (17 cycles at default). Next start accepted the cycle after done (back-to-back
//    throughput ITER+2 cycles).
//  - start while busy: ignored, no effect on operands or result.
//  - a/b may change freely after start accepted; only latched copies are used.
//  - product is updated only in DONE; never shows partial sums.
//  - Reset mid-operation: operation discarded, no done pulse, product=0.
//  - busy=1 exactly in RUN and DONE; busy=0 in the cycle after done.
// CONFIGURATION
//  MUL_EARLY_EXIT_EN defined:
//   - RUN exits to DONE as soon as shifted b_r==0 after an update (all remaining
//     digits zero); start with b==0 goes IDLE->DONE directly (zero RUN cycles).
//   - Latency = (index of highest nonzero digit of b)+1 RUN cycles + 1; result identical.
//   - Data-dependent timing: not for secret operands; off for signing paths.
//  MUL_EARLY_EXIT_EN undefined (default): always exactly ITER RUN cycles,
//   constant-time regardless of operand values.
// TESTING
//  1) a=0, b=2^256-1 -> product=0, done at cycle 17 (default build), busy low at 18.
//  2) a=1, b=2^255-20 -> product=2^255-20 zero-extended to 512 bits.
//  3) a=b=2^256-1 -> product=2^512-2^257+1; exactly one done pulse at cycle 17.
//  4) a=2^255-19, b=2^255-19 -> product=(2^255-19)^2; feed into reducer -> mod=0.
//  5) start pulsed again at cycles 3 and 10 with new a/b -> ignored; first result
//     unchanged; new start after done accepted and correct.
//  6) rst asserted at cycle 8 of an operation -> busy,done,product 0 immediately;
//     no done pulse; following operation correct.
//  7) (MUL_EARLY_EXIT_EN) a=5, b=3 -> product=15, done at cycle 2; b=0 -> done at cycle 1.

Source files
------------

// File: rtl/seq_mul_256bit_if.sv
// Operand/result bus of the 256x256 sequential multiplier.
// The master issues start with a/b; the slave answers with busy, a done pulse and the product.
interface seq_mul_256bit_if;
    logic         start;
    logic [255:0] a;
    logic [255:0] b;
    logic         busy;
    logic         done;
    logic [511:0] product;
    logic [1:0]   dbg_state;

    // start is sampled only while the multiplier is idle; done is a one-cycle pulse,
    // and product holds its value until the next done.
    modport master (output start, a, b, input busy, done, product, dbg_state);
    modport slave  (input start, a, b, output busy, done, product, dbg_state);
endinterface

// File: rtl/seq_mul_256bit.sv
// Digit-serial 256x256 unsigned multiplier: one DIGIT_W-bit digit of b per RUN cycle, LSB first.
// Optional MUL_EARLY_EXIT_EN: finish once the remaining digits of b are all zero (data-dependent timing).
module seq_mul_256bit #(
    parameter int DIGIT_W = 16
) (
    input logic              clk,
    input logic              rst,
    seq_mul_256bit_if.slave  bus
);
    localparam int ITER  = 256 / DIGIT_W;
    localparam int CNT_W = $clog2(ITER + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITER - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    logic [255:0]       r_a;
    logic [255:0]       r_b;
    logic [511:0]       r_acc;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_busy;
    logic               r_done;
    logic [511:0]       r_product;

    logic [DIGIT_W-1:0]     w_digit;
    logic [255+DIGIT_W:0]   w_pp;
    logic [511:0]           w_pp_ext;
    logic [8:0]             w_shamt;
    logic [511:0]           w_acc_next;
    logic [255:0]           w_b_next;
    logic                   w_exit;

    assign w_digit    = r_b[DIGIT_W-1:0];
    assign w_pp       = {{DIGIT_W{1'b0}}, r_a} * {{256{1'b0}}, w_digit};
    assign w_pp_ext   = {{(256-DIGIT_W){1'b0}}, w_pp};
    assign w_shamt    = 9'(r_cnt) * 9'(DIGIT_W);
    // The product of two 256-bit values fits in 512 bits, so the sum never carries out.
    assign w_acc_next = r_acc + (w_pp_ext << w_shamt);
    assign w_b_next   = r_b >> DIGIT_W;

`ifdef MUL_EARLY_EXIT_EN
    assign w_exit = (r_cnt == CNT_LAST) || (w_b_next == '0);
`else
    assign w_exit = (r_cnt == CNT_LAST);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_a       <= '0;
            r_b       <= '0;
            r_acc     <= '0;
            r_cnt     <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_product <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_a    <= bus.a;
                        r_b    <= bus.b;
                        r_acc  <= '0;
                        r_cnt  <= '0;
                        r_busy <= 1'b1;
`ifdef MUL_EARLY_EXIT_EN
                        r_state <= (bus.b == '0) ? S_DONE : S_RUN;
`else
                        r_state <= S_RUN;
`endif
                    end else begin
                        // busy stays up through the done cycle and drops on the edge after it
                        r_busy <= 1'b0;
                    end
                end
                S_RUN: begin
                    r_acc <= w_acc_next;
                    r_b   <= w_b_next;
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (w_exit) r_state <= S_DONE;
                end
                S_DONE: begin
                    r_product <= r_acc;
                    r_done    <= 1'b1;
                    r_state   <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.product   = r_product;
    assign bus.dbg_state = r_state;
endmodule

// File: tb/tb_seq_mul_256bit.sv
// Directed-vector bench for seq_mul_256bit: stimulus pushes expected products, a monitor pops them on done.
module tb_seq_mul_256bit;
    localparam int DW   = 16;
    localparam int ITER = 256 / DW;

    localparam logic [255:0] ONES    = {256{1'b1}};
    localparam logic [255:0] P255M20 = {4'h7, {61{4'hf}}, 8'hec};
    localparam logic [255:0] P25519  = {4'h7, {61{4'hf}}, 8'hed};
    localparam logic [511:0] P_SQ    = {4'h3, {61{4'hf}}, 8'hed, 247'b0, 9'h169};
    localparam logic [511:0] ONES_SQ = {{255{1'b1}}, 1'b0, {255{1'b0}}, 1'b1};
    localparam logic [511:0] ONES_X2 = {255'b0, 1'b1, {255{1'b1}}, 1'b0};

    // clock / reset
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    seq_mul_256bit_if bus();
    seq_mul_256bit #(.DIGIT_W(DW)) dut (.clk(clk), .rst(rst), .bus(bus));

    // scoreboard
    logic [511:0] exp_q[$];
    int           t0_q[$];
    int           lat_q[$];
    int           n_pass  = 0;
    int           n_total = 0;
    logic [511:0] last_prod = '0;
    logic [511:0] m_exp;
    int           m_t0;
    int           m_lat;

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // negedge-of-drive to negedge-of-done distance; accept edge adds one
    function automatic int exp_lat(input logic [255:0] b);
`ifdef MUL_EARLY_EXIT_EN
        int hi = -1;
        for (int i = 0; i < ITER; i++)
            if (b[i*DW +: DW] != '0) hi = i;
        return hi + 1 + 2;
`else
        return ITER + 2;
`endif
    endfunction

    // monitor
    always @(negedge clk) begin
        if (rst) begin
            last_prod = '0;
        end else if (bus.done) begin
            if (exp_q.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_done: got done=1 at cycle %0d expected no done", cyc);
            end else begin
                m_exp = exp_q.pop_front();
                m_t0  = t0_q.pop_front();
                m_lat = lat_q.pop_front();
                chk("product", bus.product, m_exp);
                chk("latency", 512'(cyc - m_t0), 512'(m_lat));
                chk("busy_with_done", 512'(bus.busy), 512'(1));
            end
            last_prod = bus.product;
        end else begin
            chk("product_hold", bus.product, last_prod);
        end
    end

    // drivers: called on a negedge, return on the negedge after the accepting edge
    task automatic issue(input logic [255:0] ta, input logic [255:0] tb, input logic [511:0] texp);
        bus.start = 1'b1;
        bus.a     = ta;
        bus.b     = tb;
        exp_q.push_back(texp);
        t0_q.push_back(cyc);
        lat_q.push_back(exp_lat(tb));
        @(negedge clk);
        bus.start = 1'b0;
        bus.a     = {8{$urandom()}};
        bus.b     = {8{$urandom()}};
    endtask

    task automatic wait_done();
        for (int k = 0; k < 200 && !bus.done; k++) @(negedge clk);
        if (!bus.done) begin
            n_total++;
            $display("FAIL done_timeout: got no done after 200 cycles expected a done pulse");
        end
    endtask

    task automatic check_idle_after_done();
        @(negedge clk);
        chk("busy_low_after_done", 512'(bus.busy), 512'(0));
        chk("done_single_pulse", 512'(bus.done), 512'(0));
    endtask

    initial begin
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        repeat (3) @(negedge clk);
        chk("reset_busy", 512'(bus.busy), 512'(0));
        chk("reset_done", 512'(bus.done), 512'(0));
        chk("reset_product", bus.product, 512'(0));
        chk("reset_state", 512'(bus.dbg_state), 512'(0));
        #2 rst = 1'b0;
        @(negedge clk);

        issue('0, ONES, '0);
        wait_done();
        check_idle_after_done();

        issue(256'd1, P255M20, {256'b0, P255M20});
        wait_done();
        // back-to-back: start presented in the done cycle
        issue(ONES, ONES, ONES_SQ);
        wait_done();
        check_idle_after_done();

        issue(P25519, P25519, P_SQ);
        wait_done();
        issue(ONES, 256'd2, ONES_X2);
        wait_done();
        issue(256'h1234, 256'h10000, 512'h12340000);
        wait_done();
        issue(256'd5, 256'd3, 512'd15);
        wait_done();
        check_idle_after_done();

        // start while busy must be ignored
        issue(256'd3, 256'd7, 512'd21);
        bus.start = 1'b1; bus.a = ONES; bus.b = ONES;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (5) @(negedge clk);
        bus.start = 1'b1; bus.a = P25519; bus.b = ONES;
        @(negedge clk);
        bus.start = 1'b0;
        wait_done();
        check_idle_after_done();
        issue(256'h1234, 256'h10000, 512'h12340000);
        wait_done();
        check_idle_after_done();

        // reset in the middle of an operation
        issue(ONES, ONES, ONES_SQ);
        repeat (6) @(negedge clk);
        #2 rst = 1'b1;
        void'(exp_q.pop_back());
        void'(t0_q.pop_back());
        void'(lat_q.pop_back());
        #1;
        chk("midrst_busy", 512'(bus.busy), 512'(0));
        chk("midrst_done", 512'(bus.done), 512'(0));
        chk("midrst_product", bus.product, 512'(0));
        chk("midrst_state", 512'(bus.dbg_state), 512'(0));
        @(negedge clk);
        #2 rst = 1'b0;
        repeat (25) @(negedge clk);
        issue(256'd5, 256'd3, 512'd15);
        wait_done();
        check_idle_after_done();

        issue(ONES, '0, '0);
        wait_done();
        check_idle_after_done();

        repeat (3) @(negedge clk);
        chk("queue_empty", 512'(exp_q.size()), 512'(0));
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
